down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer.sv | 98 +++++++++
 tb/tb_down_timer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and default width.
package down_timer_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down counter with start/stop/clear control, optional periodic reload
// and a one-cycle terminal-count pulse.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         auto_reload,
    output logic [N-1:0] q,
    output logic         done,
    output logic         busy,
    output logic         paused
);

    state_t       state_reg, state_next;
    logic [N-1:0] q_reg, q_next;
    logic [N-1:0] reload_reg, reload_next;
    logic         done_reg, done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
        end
    end

    // Priority within a cycle is clear, then stop, then start.
    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            q_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!stop && start) begin
                        q_next      = load_val;
                        reload_next = load_val;
                        if (load_val == '0) begin
                            // Zero load terminates immediately without entering RUN.
                            done_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_PAUSE;
                    end else if (q_reg > N'(1)) begin
                        q_next = q_reg - N'(1);
                    end else if (q_reg == N'(1)) begin
                        q_next    = '0;
                        done_next = 1'b1;
                    end else if (auto_reload) begin
                        q_next = reload_reg;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (!stop && start) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    q_next     = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy   = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
        paused = (state_reg == ST_PAUSE);
    end

    assign q    = q_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: each driven cycle queues the outputs expected
// after the next clock edge; a negedge monitor pops and compares them.
module tb_down_timer;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] load_val;
    logic         start;
    logic         stop;
    logic         clear;
    logic         auto_reload;
    logic [N-1:0] q;
    logic         done;
    logic         busy;
    logic         paused;

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] q;
        logic         done;
        logic         busy;
        logic         paused;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    down_timer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .auto_reload(auto_reload),
        .q          (q),
        .done       (done),
        .busy       (busy),
        .paused     (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("q",      32'(q),      32'(e.q));
            check("done",   32'(done),   32'(e.done));
            check("busy",   32'(busy),   32'(e.busy));
            check("paused", 32'(paused), 32'(e.paused));
        end
    end

    // Called at posedge+1: drive inputs for the coming edge and queue its expected outputs.
    task automatic step(input logic st, input logic sp, input logic cl, input logic ar,
                        input logic [N-1:0] lv, input logic [N-1:0] eq, input logic ed,
                        input logic eb, input logic ep);
        exp_t e;
        start       = st;
        stop        = sp;
        clear       = cl;
        auto_reload = ar;
        load_val    = lv;
        e.cyc    = cyc + 1;
        e.q      = eq;
        e.done   = ed;
        e.busy   = eb;
        e.paused = ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        auto_reload = 1'b0;
        load_val    = '0;
        @(posedge clk);
        #1;
        check("rst_q",      32'(q),      32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // One-shot count from 5, with stop alone in IDLE beforehand.
        $display("txn one_shot load=5");
        step(0, 1, 0, 0, 16'd5, 16'd0, 0, 0, 0);
        for (int v = 5; v >= 0; v--)
            step(v == 5, 0, 0, 0, 16'd5, 16'(v), v == 0, 1, 0);
        step(0, 0, 0, 0, 16'd5, 16'd0, 0, 0, 0);
        step(0, 0, 0, 0, 16'd5, 16'd0, 0, 0, 0);

        // Periodic mode: done every 4 cycles, then clear.
        $display("txn auto_reload load=3");
        for (int i = 0; i < 9; i++)
            step(i == 0, 0, 0, 1, 16'd3, 16'(3 - (i % 4)), (i % 4) == 3, 1, 0);
        step(0, 0, 1, 1, 16'd3, 16'd0, 0, 0, 0);
        step(0, 0, 0, 0, 16'd3, 16'd0, 0, 0, 0);

        // Pause at 6 for four cycles (one with start+stop), resume with start held high.
        $display("txn pause_resume load=10");
        for (int v = 10; v >= 6; v--)
            step(v == 10, 0, 0, 0, 16'd10, 16'(v), 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step(i == 2, 1, 0, 0, 16'd10, 16'd6, 0, 1, 1);
        step(1, 0, 0, 0, 16'd10, 16'd6, 0, 1, 0);
        for (int v = 5; v >= 0; v--)
            step(v != 0, 0, 0, 0, 16'd10, 16'(v), v == 0, 1, 0);
        step(0, 0, 0, 0, 16'd10, 16'd0, 0, 0, 0);

        // Zero load: immediate single done pulse, no RUN.
        $display("txn zero_load");
        step(1, 0, 0, 0, 16'd0, 16'd0, 1, 0, 0);
        step(0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0);
        step(0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0);

        // Clear wins over stop and start at q=4.
        $display("txn clear_priority load=8");
        for (int v = 8; v >= 4; v--)
            step(v == 8, 0, 0, 0, 16'd8, 16'(v), 0, 1, 0);
        step(1, 1, 1, 0, 16'd8, 16'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 16'd8, 16'd0, 0, 0, 0);

        // Long count interrupted by asynchronous reset at 0x8000.
        $display("txn async_reset load=ffff");
        for (int v = 32'hFFFF; v >= 32'h8000; v--)
            step(v == 32'hFFFF, 0, 0, 0, 16'hFFFF, 16'(v), 0, 1, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_q",      32'(q),      32'd0);
        check("async_done",   32'(done),   32'd0);
        check("async_busy",   32'(busy),   32'd0);
        check("async_paused", 32'(paused), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 16'hFFFF, 16'd0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
